pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with return-address stack and sticky stack error flags
module pc_sequencer #(
    parameter int PC_W  = 12,
    parameter int OFF_W = 8,
    parameter int DEPTH = 8,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [1:0]       pc_src,
    input  logic             call,
    input  logic [PC_W-1:0]  jump_target,
    input  logic [OFF_W-1:0] offset,
    input  logic             clear_flags,
    output logic [PC_W-1:0]  pc,
    output logic [SP_W-1:0]  sp,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_overflow,
    output logic             stack_underflow
);

    // Stack memory is addressed by entry number; sp counts valid entries so it
    // needs one more code point than the index does.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] SRC_INC = 2'b00;
    localparam logic [1:0] SRC_ABS = 2'b01;
    localparam logic [1:0] SRC_RET = 2'b10;
    localparam logic [1:0] SRC_REL = 2'b11;

    logic [PC_W-1:0]  stack_mem [DEPTH];

    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  pc_rel;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [PC_W-1:0]  top_entry;

    logic [PC_W-1:0]  pc_next;
    logic [SP_W-1:0]  sp_next;
    logic             do_push;
    logic             set_ovf;
    logic             set_udf;
    logic             push_en;

    // Address arithmetic shared by the increment, relative and return paths;
    // every sum simply wraps at the PC width.
    assign pc_inc   = pc + PC_W'(1);
    assign off_ext  = PC_W'($signed(offset));
    assign pc_rel   = pc_inc + off_ext;

    // Push goes to entry sp, pop reads entry sp-1; both are only used when the
    // corresponding full/empty guard is false, so the truncation never aliases.
    assign push_idx  = IDX_W'(sp);
    assign top_idx   = IDX_W'(sp - SP_W'(1));
    assign top_entry = stack_mem[top_idx];

    assign stack_full  = (sp == SP_W'(DEPTH));
    assign stack_empty = (sp == SP_W'(0));

    // Next-state decode: choose the new pc, stack movement and any error to raise.
    always_comb begin
        pc_next = pc;
        sp_next = sp;
        do_push = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        case (pc_src)
            SRC_INC: begin
                pc_next = pc_inc;
            end
            SRC_ABS: begin
                pc_next = jump_target;
                if (call) begin
                    if (stack_full) begin
                        set_ovf = 1'b1;
                    end else begin
                        do_push = 1'b1;
                        sp_next = sp + SP_W'(1);
                    end
                end
            end
            SRC_RET: begin
                if (stack_empty) begin
                    set_udf = 1'b1;
                    pc_next = pc_inc;
                end else begin
                    pc_next = top_entry;
                    sp_next = sp - SP_W'(1);
                end
            end
            SRC_REL: begin
                pc_next = pc_rel;
            end
            default: begin
                pc_next = pc_inc;
            end
        endcase
    end

    // A push during reset or stall would be harmless to sp but is suppressed so
    // an abandoned call leaves no trace even in the don't-care entries.
    assign push_en = do_push && !stall && rst_n;

    // Program counter and stack pointer registers, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            sp <= '0;
        end else if (!stall) begin
            pc <= pc_next;
            sp <= sp_next;
        end
    end

    // Sticky error flags: a fresh error on the same edge beats clear_flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (!stall) begin
            stack_overflow  <= set_ovf | (stack_overflow  & ~clear_flags);
            stack_underflow <= set_udf | (stack_underflow & ~clear_flags);
        end
    end

    // Return-address storage; contents are not reset since only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  pc_src;
    logic        call;
    logic [11:0] jump_target;
    logic [7:0]  offset;
    logic        clear_flags;
    logic [11:0] pc;
    logic [3:0]  sp;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_overflow;
    logic        stack_underflow;

    int total;
    int bad;

    pc_sequencer #(.PC_W(12), .OFF_W(8), .DEPTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .pc_src(pc_src),
        .call(call),
        .jump_target(jump_target),
        .offset(offset),
        .clear_flags(clear_flags),
        .pc(pc),
        .sp(sp),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of inputs for one rising edge, then settle 1ns past it.
    task automatic cyc(input logic [1:0] src, input logic c, input logic [11:0] tgt,
                       input logic [7:0] off, input logic clr, input logic stl);
        pc_src = src; call = c; jump_target = tgt; offset = off; clear_flags = clr; stall = stl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_pc got=%h want=000", pc); end
        total++; if (sp !== 4'd0) begin bad++; $display("FAIL reset_sp got=%0d want=0", sp); end
        total++; if ({stack_empty, stack_full} !== 2'b10) begin bad++; $display("FAIL reset_empty_full got=%b want=10", {stack_empty, stack_full}); end
        total++; if ({stack_overflow, stack_underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {stack_overflow, stack_underflow}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (pc !== 12'h000) begin bad++; $display("FAIL release_pc got=%h want=000", pc); end
    endtask

    task automatic test_increment;
        for (int i = 1; i <= 5; i++) begin
            cyc(2'b00, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
            total++; if (pc !== 12'(i)) begin bad++; $display("FAIL inc_pc step=%0d got=%h want=%h", i, pc, 12'(i)); end
            total++; if (sp !== 4'd0 || stack_empty !== 1'b1) begin bad++; $display("FAIL inc_sp step=%0d got=%0d/%b want=0/1", i, sp, stack_empty); end
        end
    endtask

    task automatic test_call_return;
        cyc(2'b01, 1'b0, 12'h010, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h010 || sp !== 4'd0) begin bad++; $display("FAIL jump_nocall got=%h/%0d want=010/0", pc, sp); end
        cyc(2'b01, 1'b1, 12'h200, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h200 || sp !== 4'd1) begin bad++; $display("FAIL call got=%h/%0d want=200/1", pc, sp); end
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h011 || sp !== 4'd0) begin bad++; $display("FAIL return got=%h/%0d want=011/0", pc, sp); end
        cyc(2'b00, 1'b1, 12'h3AA, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h012 || sp !== 4'd0 || stack_overflow !== 1'b0) begin bad++; $display("FAIL call_ignored got=%h/%0d/%b want=012/0/0", pc, sp, stack_overflow); end
    endtask

    task automatic test_relative;
        cyc(2'b01, 1'b0, 12'h100, 8'h00, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 12'h000, 8'hFE, 1'b0, 1'b0);
        total++; if (pc !== 12'h0FF) begin bad++; $display("FAIL rel_neg got=%h want=0FF", pc); end
        cyc(2'b11, 1'b0, 12'h000, 8'h05, 1'b0, 1'b0);
        total++; if (pc !== 12'h105) begin bad++; $display("FAIL rel_pos got=%h want=105", pc); end
        cyc(2'b11, 1'b1, 12'h000, 8'h80, 1'b0, 1'b0);
        total++; if (pc !== 12'h086 || sp !== 4'd0) begin bad++; $display("FAIL rel_min got=%h/%0d want=086/0", pc, sp); end
        cyc(2'b01, 1'b0, 12'hFFF, 8'h00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h000) begin bad++; $display("FAIL inc_wrap got=%h want=000", pc); end
        cyc(2'b01, 1'b0, 12'hFFF, 8'h00, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 12'h000, 8'h01, 1'b0, 1'b0);
        total++; if (pc !== 12'h001) begin bad++; $display("FAIL rel_wrap got=%h want=001", pc); end
    endtask

    task automatic test_overflow_underflow;
        logic [11:0] want;
        cyc(2'b01, 1'b0, 12'h050, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(2'b01, 1'b1, 12'h100 + 12'(16 * i), 8'h00, 1'b0, 1'b0);
            total++; if (sp !== 4'(i + 1)) begin bad++; $display("FAIL push_sp i=%0d got=%0d want=%0d", i, sp, i + 1); end
        end
        total++; if (stack_full !== 1'b1 || stack_overflow !== 1'b0) begin bad++; $display("FAIL full8 got=%b/%b want=1/0", stack_full, stack_overflow); end
        cyc(2'b01, 1'b1, 12'h300, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h300 || sp !== 4'd8 || stack_full !== 1'b1 || stack_overflow !== 1'b1) begin
            bad++; $display("FAIL overflow got=%h/%0d/%b/%b want=300/8/1/1", pc, sp, stack_full, stack_overflow);
        end
        for (int i = 7; i >= 0; i--) begin
            want = (i == 0) ? 12'h051 : 12'h101 + 12'(16 * (i - 1));
            cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
            total++; if (pc !== want || sp !== 4'(i)) begin bad++; $display("FAIL pop i=%0d got=%h/%0d want=%h/%0d", i, pc, sp, want, i); end
        end
        total++; if (stack_underflow !== 1'b0) begin bad++; $display("FAIL early_udf got=%b want=0", stack_underflow); end
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h052 || sp !== 4'd0 || stack_underflow !== 1'b1 || stack_overflow !== 1'b1) begin
            bad++; $display("FAIL underflow got=%h/%0d/%b/%b want=052/0/1/1", pc, sp, stack_underflow, stack_overflow);
        end
    endtask

    task automatic test_stall_clear;
        cyc(2'b01, 1'b1, 12'h3AA, 8'h00, 1'b1, 1'b1);
        total++; if (pc !== 12'h052 || sp !== 4'd0) begin bad++; $display("FAIL stall_hold got=%h/%0d want=052/0", pc, sp); end
        total++; if ({stack_overflow, stack_underflow} !== 2'b11) begin bad++; $display("FAIL stall_clear_ignored got=%b want=11", {stack_overflow, stack_underflow}); end
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0);
        total++; if ({stack_overflow, stack_underflow} !== 2'b01 || pc !== 12'h053) begin
            bad++; $display("FAIL clear_vs_udf got=%b/%h want=01/053", {stack_overflow, stack_underflow}, pc);
        end
        cyc(2'b00, 1'b0, 12'h000, 8'h00, 1'b1, 1'b0);
        total++; if ({stack_overflow, stack_underflow} !== 2'b00) begin bad++; $display("FAIL clear got=%b want=00", {stack_overflow, stack_underflow}); end
        cyc(2'b01, 1'b1, 12'h020, 8'h00, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1);
        total++; if (pc !== 12'h020 || sp !== 4'd1) begin bad++; $display("FAIL stall_pop got=%h/%0d want=020/1", pc, sp); end
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h055 || sp !== 4'd0) begin bad++; $display("FAIL pop_after_stall got=%h/%0d want=055/0", pc, sp); end
    endtask

    task automatic test_async_reset;
        cyc(2'b01, 1'b1, 12'h400, 8'h00, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 12'h500, 8'h00, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 12'h600, 8'h00, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 12'h700, 8'h00, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        cyc(2'b10, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 12'h400, 8'h00, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 12'h500, 8'h00, 1'b0, 1'b0);
        cyc(2'b01, 1'b1, 12'h600, 8'h00, 1'b0, 1'b0);
        total++; if (sp !== 4'd3 || pc !== 12'h600 || stack_underflow !== 1'b1) begin
            bad++; $display("FAIL pre_reset got=%0d/%h/%b want=3/600/1", sp, pc, stack_underflow);
        end
        pc_src = 2'b01; call = 1'b1; jump_target = 12'h7A0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pc !== 12'h000 || sp !== 4'd0 || {stack_overflow, stack_underflow} !== 2'b00) begin
            bad++; $display("FAIL async_reset got=%h/%0d/%b want=000/0/00", pc, sp, {stack_overflow, stack_underflow});
        end
        @(posedge clk);
        #1;
        total++; if (pc !== 12'h000 || sp !== 4'd0) begin bad++; $display("FAIL reset_abandon got=%h/%0d want=000/0", pc, sp); end
        #2;
        rst_n = 1'b1;
        cyc(2'b00, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0);
        total++; if (pc !== 12'h001 || sp !== 4'd0 || stack_empty !== 1'b1) begin
            bad++; $display("FAIL post_reset got=%h/%0d/%b want=001/0/1", pc, sp, stack_empty);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        pc_src = 2'b00;
        call = 1'b0;
        jump_target = 12'h000;
        offset = 8'h00;
        clear_flags = 1'b0;
        test_reset;
        test_increment;
        test_call_return;
        test_relative;
        test_overflow_underflow;
        test_stall_clear;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
